mil_1553_txd: RTL and testbench

MIL_1553_TXD -- requirements
Module: mil_1553_txd

---
 rtl/mil_1553_txd.sv | 103 ++++++++++
 tb/tb_mil_1553_txd.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mil_1553_txd.sv
// MIL-STD-1553 word transmitter: sync, 16 data bits MSB first, odd parity,
// Manchester-II line drive on TXP/TXN at 1 Mbit/s from a 50 MHz clock.
module mil_1553_txd (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dat,
  input  logic        txen,
  output logic        TXP,
  output logic        TXN,
  output logic        SY1,
  output logic        SY2,
  output logic        en_tx,
  output logic        T_dat,
  output logic        T_end,
  output logic        SDAT,
  output logic        FT_cp,
  output logic [4:0]  cb_bit,
  output logic        ce_tact
);

  typedef enum logic {IDLE, XMIT} state_t;

  state_t      state, state_d;
  logic [4:0]  div;
  logic        hb;
  logic [15:0] sr;
  logic        last_half;
  logic        line_bit;

  assign ce_tact   = (div == 5'd24);
  assign last_half = hb && (cb_bit == 5'd19);

  always_ff @(posedge clk) begin
    if (rst) div <= '0;
    else     div <= ce_tact ? 5'd0 : div + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (ce_tact) begin
      unique case (state)
        IDLE: if (txen) state_d = XMIT;
        XMIT: if (last_half && !txen) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign en_tx = (state == XMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cb_bit <= '0;
      hb     <= 1'b0;
      sr     <= '0;
      FT_cp  <= 1'b0;
    end else if (ce_tact) begin
      if (!en_tx) begin
        cb_bit <= '0;
        hb     <= 1'b0;
      end else begin
        hb <= ~hb;
        if (hb) begin
          // word end: restart or stop, next word always begins at bit 0
          if (cb_bit == 5'd19) begin
            cb_bit <= '0;
            hb     <= 1'b0;
          end else begin
            cb_bit <= cb_bit + 5'd1;
          end
          if (cb_bit == 5'd2) begin
            sr    <= dat;
            FT_cp <= 1'b1;
          end else if (cb_bit >= 5'd3 && cb_bit <= 5'd18) begin
            sr <= {sr[14:0], 1'b0};
            if (sr[15]) FT_cp <= ~FT_cp;
          end
        end
      end
    end
  end

  assign SDAT  = sr[15];
  assign SY1   = en_tx && ((cb_bit == 5'd0) || (cb_bit == 5'd1 && !hb));
  assign SY2   = en_tx && ((cb_bit == 5'd1 && hb) || (cb_bit == 5'd2));
  assign T_dat = en_tx && (cb_bit >= 5'd3) && (cb_bit <= 5'd18);
  assign T_end = en_tx && (cb_bit == 5'd19);

  always_comb begin
    line_bit = 1'b0;
    if (T_dat)      line_bit = SDAT ^ hb;
    else if (T_end) line_bit = FT_cp ^ hb;
  end

  assign TXP = en_tx && (SY1 || line_bit);
  assign TXN = en_tx && !TXP;

endmodule

// File: tb/tb_mil_1553_txd.sv
// Directed bench for mil_1553_txd: idle, single word, back-to-back,
// mid-word txen drop and mid-word reset, with a TXP/TXN exclusion monitor.
module tb_mil_1553_txd;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dat;
  logic        txen;
  logic        TXP, TXN, SY1, SY2, en_tx, T_dat, T_end, SDAT, FT_cp, ce_tact;
  logic [4:0]  cb_bit;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon    = 1'b0;

  always #10 clk = ~clk;

  mil_1553_txd dut (
    .clk(clk), .rst(rst), .dat(dat), .txen(txen),
    .TXP(TXP), .TXN(TXN), .SY1(SY1), .SY2(SY2),
    .en_tx(en_tx), .T_dat(T_dat), .T_end(T_end),
    .SDAT(SDAT), .FT_cp(FT_cp), .cb_bit(cb_bit), .ce_tact(ce_tact)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (mon) chk("excl", {31'd0, TXP & TXN}, 32'd0);

  task automatic wait_en(input int limit);
    int n;
    n = 0;
    while (!en_tx && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("en_rise", {31'd0, en_tx}, 32'd1);
  endtask

  // Starts at the first negedge of a word; ends on the first negedge after it.
  task automatic word(input logic [15:0] d, input logic p,
                      input logic [15:0] nd, input logic ntx);
    logic e;
    for (int k = 0; k < 40; k++) begin
      repeat (k == 0 ? 12 : 25) @(negedge clk);
      if (k < 3)       e = 1'b1;
      else if (k < 6)  e = 1'b0;
      else if (k < 38) e = d[15 - (k - 6) / 2] ^ k[0];
      else             e = p ^ k[0];
      chk($sformatf("txp[%0d]", k), {31'd0, TXP}, {31'd0, e});
      chk($sformatf("txn[%0d]", k), {31'd0, TXN}, {31'd0, ~e});
      chk($sformatf("cb[%0d]", k), {27'd0, cb_bit}, k / 2);
      if (k == 1)  chk("sy1", {31'd0, SY1}, 32'd1);
      if (k == 4)  chk("sy2", {31'd0, SY2}, 32'd1);
      if (k == 20) chk("tdat", {31'd0, T_dat}, 32'd1);
      if (k == 38) begin
        chk("tend", {31'd0, T_end}, 32'd1);
        chk("parity", {31'd0, FT_cp}, {31'd0, p});
      end
      if (k == 10) begin
        dat  = nd;
        txen = ntx;
      end
    end
    repeat (12) @(negedge clk);
    chk("en_last", {31'd0, en_tx}, 32'd1);
    @(negedge clk);
    chk("en_next", {31'd0, en_tx}, {31'd0, ntx});
  endtask

  initial begin
    int n;
    rst  = 1'b1;
    dat  = 16'h0000;
    txen = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txp", {31'd0, TXP}, 32'd0);
    chk("rst_txn", {31'd0, TXN}, 32'd0);
    chk("rst_en", {31'd0, en_tx}, 32'd0);
    chk("rst_ce", {31'd0, ce_tact}, 32'd0);
    chk("rst_cb", {27'd0, cb_bit}, 32'd0);
    rst = 1'b0;
    mon = 1'b1;

    // idle: ce_tact period
    n = 0;
    while (!ce_tact && n < 40) begin @(negedge clk); n++; end
    chk("ce_first", {31'd0, ce_tact}, 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ce_tact && n < 40);
    chk("ce_period", n, 32'd25);
    chk("idle_txp", {31'd0, TXP}, 32'd0);
    chk("idle_txn", {31'd0, TXN}, 32'd0);
    chk("idle_en", {31'd0, en_tx}, 32'd0);

    // single word
    dat  = 16'h1234;
    txen = 1'b1;
    wait_en(60);
    word(16'h1234, 1'b0, 16'h1234, 1'b0);
    repeat (5) @(negedge clk);
    chk("post1_txp", {31'd0, TXP}, 32'd0);
    chk("post1_txn", {31'd0, TXN}, 32'd0);

    // back-to-back, then txen drop in word 3
    repeat (30) @(negedge clk);
    dat  = 16'h1234;
    txen = 1'b1;
    wait_en(60);
    word(16'h1234, 1'b0, 16'h5678, 1'b1);
    word(16'h5678, 1'b1, 16'h0000, 1'b1);
    word(16'h0000, 1'b1, 16'h0000, 1'b0);
    repeat (100) @(negedge clk);
    chk("post3_en", {31'd0, en_tx}, 32'd0);
    chk("post3_txp", {31'd0, TXP}, 32'd0);
    chk("post3_txn", {31'd0, TXN}, 32'd0);

    // reset mid-word
    dat  = 16'hFFFF;
    txen = 1'b1;
    wait_en(60);
    n = 0;
    while (cb_bit != 5'd10 && n < 1000) begin @(negedge clk); n++; end
    chk("cb10", {27'd0, cb_bit}, 32'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_txp", {31'd0, TXP}, 32'd0);
    chk("mrst_txn", {31'd0, TXN}, 32'd0);
    chk("mrst_en", {31'd0, en_tx}, 32'd0);
    chk("mrst_cb", {27'd0, cb_bit}, 32'd0);
    chk("mrst_ft", {31'd0, FT_cp}, 32'd0);
    chk("mrst_sd", {31'd0, SDAT}, 32'd0);
    mon  = 1'b0;
    rst  = 1'b0;
    txen = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
